// File: rtl/sys_cmd_sched_pkg.sv
// sys_cmd_sched_pkg: shared command opcodes, FSM state encoding and ALU operand addresses.
package sys_cmd_sched_pkg;
  localparam logic [7:0] CMD_WR  = 8'hAA;
  localparam logic [7:0] CMD_RD  = 8'hBB;
  localparam logic [7:0] CMD_OPS = 8'hCC;
  localparam logic [7:0] CMD_ALU = 8'hDD;
  localparam int OPND_A_ADDR = 0;
  localparam int OPND_B_ADDR = 1;
  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, OP_A, OP_B, ALU_FUN_ST, ALU_WAIT
  } state_t;
endpackage

// File: rtl/sys_wait_timer.sv
// sys_wait_timer: counts wait cycles after an issue; expire flags the last allowed cycle.
module sys_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic run,
  output logic expire
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or negedge RST)
    if (!RST) cnt <= '0;
    else if (load) cnt <= '0;
    else if (run) cnt <= cnt + 1'b1;
  assign expire = run && cnt == W'(TIMEOUT - 1);
endmodule

// File: rtl/sys_cmd_sched.sv
// sys_cmd_sched: decodes UART command bytes into register-file and ALU strobes.
// Read and ALU issue wait for TX_BUSY to clear; responses are guarded by a timeout.
module sys_cmd_sched
  import sys_cmd_sched_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 4,
  parameter int FUN_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RX_P_DATA,
  input  logic              RX_D_VLD,
  input  logic              TX_BUSY,
  input  logic              RdData_Valid,
  input  logic              ALU_OUT_VLD,
  output logic [ADDR_W-1:0] Address,
  output logic              WrEn,
  output logic [DATA_W-1:0] WrData,
  output logic              RdEn,
  output logic [FUN_W-1:0]  ALU_FUN,
  output logic              ALU_EN,
  output logic              CLK_GATE_EN,
  output logic              CMD_ERR
);
  state_t state, state_n;
  logic pend, pend_n;
  logic [ADDR_W-1:0] addr_q, addr_n, address_n;
  logic [FUN_W-1:0] fun_q, fun_n, alu_fun_n;
  logic [DATA_W-1:0] wr_data_n;
  logic wr_en_n, rd_en_n, alu_en_n, gate_n, err_n;
  logic is_wr, is_rd, is_ops, is_alu, rx_take, issue, run, expire;
  assign is_wr   = RX_P_DATA == DATA_W'(CMD_WR);
  assign is_rd   = RX_P_DATA == DATA_W'(CMD_RD);
  assign is_ops  = RX_P_DATA == DATA_W'(CMD_OPS);
  assign is_alu  = RX_P_DATA == DATA_W'(CMD_ALU);
  assign rx_take = RX_D_VLD && !pend;
  // A deferred issue fires on the first TX_BUSY-free cycle, whether or not a byte arrives with it.
  assign issue   = (state == RD_ADDR || state == ALU_FUN_ST) && !TX_BUSY && (pend || RX_D_VLD);
  assign run     = state == RD_WAIT || state == ALU_WAIT;
  sys_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .CLK(CLK), .RST(RST), .load(issue), .run(run), .expire(expire)
  );
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state  <= IDLE;
      pend   <= 1'b0;
      addr_q <= '0;
      fun_q  <= '0;
    end else begin
      state  <= state_n;
      pend   <= pend_n;
      addr_q <= addr_n;
      fun_q  <= fun_n;
    end
  always_comb begin
    state_n = state;
    pend_n  = pend;
    addr_n  = addr_q;
    fun_n   = fun_q;
    case (state)
      IDLE:
        if (RX_D_VLD)
          state_n = is_wr ? WR_ADDR : is_rd ? RD_ADDR : is_ops ? OP_A : is_alu ? ALU_FUN_ST : IDLE;
      WR_ADDR:
        if (RX_D_VLD) begin
          addr_n  = RX_P_DATA[ADDR_W-1:0];
          state_n = WR_DATA;
        end
      WR_DATA:    if (RX_D_VLD) state_n = IDLE;
      OP_A:       if (RX_D_VLD) state_n = OP_B;
      OP_B:       if (RX_D_VLD) state_n = ALU_FUN_ST;
      RD_ADDR: begin
        if (rx_take) addr_n = RX_P_DATA[ADDR_W-1:0];
        pend_n  = issue ? 1'b0 : pend | RX_D_VLD;
        state_n = issue ? RD_WAIT : RD_ADDR;
      end
      ALU_FUN_ST: begin
        if (rx_take) fun_n = RX_P_DATA[FUN_W-1:0];
        pend_n  = issue ? 1'b0 : pend | RX_D_VLD;
        state_n = issue ? ALU_WAIT : ALU_FUN_ST;
      end
      RD_WAIT:    if (RdData_Valid || expire) state_n = IDLE;
      ALU_WAIT:   if (ALU_OUT_VLD || expire) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end
  always_comb begin
    address_n = Address;
    wr_data_n = WrData;
    alu_fun_n = ALU_FUN;
    wr_en_n   = 1'b0;
    rd_en_n   = 1'b0;
    alu_en_n  = 1'b0;
    err_n     = 1'b0;
    gate_n    = state_n == ALU_WAIT;
    case (state)
      IDLE: err_n = RX_D_VLD && !(is_wr || is_rd || is_ops || is_alu);
      WR_DATA, OP_A, OP_B:
        if (RX_D_VLD) begin
          wr_en_n   = 1'b1;
          wr_data_n = RX_P_DATA;
          address_n = state == WR_DATA ? addr_q :
                      state == OP_A ? ADDR_W'(OPND_A_ADDR) : ADDR_W'(OPND_B_ADDR);
        end
      RD_ADDR: begin
        err_n = RX_D_VLD && pend;
        if (issue) begin
          rd_en_n   = 1'b1;
          address_n = addr_n;
        end
      end
      ALU_FUN_ST: begin
        err_n = RX_D_VLD && pend;
        if (issue) begin
          alu_en_n  = 1'b1;
          alu_fun_n = fun_n;
        end
      end
      RD_WAIT:  err_n = RX_D_VLD || (expire && !RdData_Valid);
      ALU_WAIT: err_n = RX_D_VLD || (expire && !ALU_OUT_VLD);
      default:  err_n = 1'b0;
    endcase
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      Address     <= '0;
      WrEn        <= 1'b0;
      WrData      <= '0;
      RdEn        <= 1'b0;
      ALU_FUN     <= '0;
      ALU_EN      <= 1'b0;
      CLK_GATE_EN <= 1'b0;
      CMD_ERR     <= 1'b0;
    end else begin
      Address     <= address_n;
      WrEn        <= wr_en_n;
      WrData      <= wr_data_n;
      RdEn        <= rd_en_n;
      ALU_FUN     <= alu_fun_n;
      ALU_EN      <= alu_en_n;
      CLK_GATE_EN <= gate_n;
      CMD_ERR     <= err_n;
    end
endmodule

// File: tb/tb_sys_cmd_sched.sv
// tb_sys_cmd_sched: command-level stimulus pushes expected strobes into a queue;
// a negedge monitor pops and compares each strobe and checks the clock-gate window.
module tb_sys_cmd_sched;
  localparam int TO = 255;
  logic CLK = 0, RST = 0;
  logic [7:0] RX_P_DATA = 0;
  logic RX_D_VLD = 0, TX_BUSY = 0, RdData_Valid = 0, ALU_OUT_VLD = 0;
  logic [3:0] Address, ALU_FUN;
  logic [7:0] WrData;
  logic WrEn, RdEn, ALU_EN, CLK_GATE_EN, CMD_ERR;

  sys_cmd_sched dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .TX_BUSY(TX_BUSY),
    .RdData_Valid(RdData_Valid), .ALU_OUT_VLD(ALU_OUT_VLD), .Address(Address), .WrEn(WrEn),
    .WrData(WrData), .RdEn(RdEn), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .CLK_GATE_EN(CLK_GATE_EN), .CMD_ERR(CMD_ERR)
  );

  always #5 CLK = ~CLK;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {int at; int kind; logic [7:0] adr; logic [7:0] dat;} ev_t;
  ev_t q[$];
  int tests = 0, fails = 0;
  int gate_lo = -1, gate_hi = -2;
  logic mon_en = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic take(int k, logic [7:0] a, logic [7:0] d);
    ev_t e;
    if (q.size() == 0) begin
      tests++; fails++;
      $display("FAIL unexpected strobe kind %0d at cycle %0d", k, cyc);
      return;
    end
    e = q.pop_front();
    chk("kind", k, e.kind);
    chk("cycle", cyc, e.at);
    chk("addr", a, e.adr);
    chk("data", d, e.dat);
  endtask

  always @(negedge CLK) if (mon_en) begin
    while (q.size() > 0 && q[0].at < cyc) begin
      tests++; fails++;
      $display("FAIL missing strobe kind %0d due cycle %0d", q[0].kind, q[0].at);
      void'(q.pop_front());
    end
    chk("gate", CLK_GATE_EN, cyc >= gate_lo && cyc <= gate_hi);
    if (WrEn) take(0, 8'(Address), WrData);
    if (RdEn) take(1, 8'(Address), 8'h0);
    if (ALU_EN) take(2, 8'(ALU_FUN), 8'h0);
    if (CMD_ERR) take(3, 8'h0, 8'h0);
  end

  task automatic step(); @(posedge CLK); #1; endtask
  task automatic gap(); repeat ($urandom_range(0, 2)) step(); endtask
  task automatic expect_ev(int at, int k, logic [7:0] a, logic [7:0] d);
    q.push_back('{at: at, kind: k, adr: a, dat: d});
  endtask
  task automatic send(logic [7:0] b);
    RX_P_DATA = b; RX_D_VLD = 1; step(); RX_D_VLD = 0;
  endtask

  // Final byte of a read/ALU command, optionally held off by TX_BUSY for `busy` cycles.
  task automatic issue_byte(bit alu, logic [7:0] b, int busy, bit drop);
    int t = cyc;
    TX_BUSY = busy > 0;
    if (busy == 0) expect_ev(t + 1, alu ? 2 : 1, {4'h0, b[3:0]}, 8'h0);
    send(b);
    if (busy > 0) begin
      for (int k = 1; k < busy; k++) begin
        if (drop && k == 1) begin
          RX_P_DATA = 8'($urandom); RX_D_VLD = 1; expect_ev(cyc + 1, 3, 8'h0, 8'h0);
        end
        step(); RX_D_VLD = 0;
      end
      TX_BUSY = 0;
      expect_ev(cyc + 1, alu ? 2 : 1, {4'h0, b[3:0]}, 8'h0);
      step();
    end
  endtask

  // Entered in the issue cycle; lat < 0 means no response and a timeout.
  task automatic wait_phase(bit alu, int lat, bit extra);
    int i = cyc;
    if (alu) begin gate_lo = i; gate_hi = 1 << 30; end
    if (lat < 0) begin
      if (extra) begin
        RX_P_DATA = 8'($urandom); RX_D_VLD = 1; expect_ev(i + 1, 3, 8'h0, 8'h0);
      end
      expect_ev(i + TO, 3, 8'h0, 8'h0);
      if (alu) gate_hi = i + TO - 1;
      step(); RX_D_VLD = 0;
      repeat (TO - 1) step();
    end else begin
      for (int c = 0; c <= lat; c++) begin
        RX_D_VLD = extra && c == 0;
        RX_P_DATA = 8'($urandom);
        if (RX_D_VLD) expect_ev(cyc + 1, 3, 8'h0, 8'h0);
        if (c == lat) begin
          if (alu) begin ALU_OUT_VLD = 1; gate_hi = cyc; end
          else RdData_Valid = 1;
        end
        step();
        RX_D_VLD = 0; ALU_OUT_VLD = 0; RdData_Valid = 0;
      end
    end
  endtask

  task automatic do_write(logic [7:0] a, logic [7:0] d);
    send(8'hAA); gap();
    send(a); gap();
    expect_ev(cyc + 1, 0, {4'h0, a[3:0]}, d);
    send(d); gap();
  endtask
  task automatic do_read(logic [7:0] a, int busy, bit drop, int lat, bit extra);
    send(8'hBB); gap();
    issue_byte(0, a, busy, drop);
    wait_phase(0, lat, extra); gap();
  endtask
  task automatic do_ops(logic [7:0] x, logic [7:0] y, logic [7:0] f, int busy, bit drop, int lat, bit extra);
    send(8'hCC); gap();
    expect_ev(cyc + 1, 0, 8'h0, x); send(x); gap();
    expect_ev(cyc + 1, 0, 8'h1, y); send(y); gap();
    issue_byte(1, f, busy, drop);
    wait_phase(1, lat, extra); gap();
  endtask
  task automatic do_alu(logic [7:0] f, int busy, bit drop, int lat, bit extra);
    send(8'hDD); gap();
    issue_byte(1, f, busy, drop);
    wait_phase(1, lat, extra); gap();
  endtask
  task automatic do_bad(logic [7:0] b);
    expect_ev(cyc + 1, 3, 8'h0, 8'h0); send(b); gap();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_Address"}, Address, 0);
    chk({tag, "_WrEn"}, WrEn, 0);
    chk({tag, "_WrData"}, WrData, 0);
    chk({tag, "_RdEn"}, RdEn, 0);
    chk({tag, "_ALU_FUN"}, ALU_FUN, 0);
    chk({tag, "_ALU_EN"}, ALU_EN, 0);
    chk({tag, "_CLK_GATE_EN"}, CLK_GATE_EN, 0);
    chk({tag, "_CMD_ERR"}, CMD_ERR, 0);
  endtask

  initial begin
    int k, busy, lat;
    bit drop, extra;
    logic [7:0] b;
    step(); step();
    chk_zero("reset");
    mon_en = 1; RST = 1;
    step();
    do_write(8'h05, 8'h3C);
    do_read(8'h07, 4, 0, 2, 0);
    do_ops(8'h12, 8'h34, 8'h01, 0, 0, 5, 0);
    do_alu(8'h02, 0, 0, -1, 0);
    do_bad(8'h55);
    do_alu(8'h03, 0, 0, 4, 1);
    do_read(8'hF9, 3, 1, 1, 0);
    do_write(8'h09, 8'hA5);
    send(8'hCC);
    expect_ev(cyc + 1, 0, 8'h0, 8'h12); send(8'h12);
    step();
    RST = 0; #1;
    chk_zero("midcmd_reset");
    step(); step();
    RST = 1;
    step();
    do_write(8'h0C, 8'h77);
    for (int n = 0; n < 120; n++) begin
      k = $urandom_range(0, 4);
      busy = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : 0;
      drop = busy >= 2 && $urandom_range(0, 1) == 1;
      lat = ($urandom_range(0, 39) == 0) ? -1 : $urandom_range(0, 8);
      extra = $urandom_range(0, 3) == 0;
      case (k)
        0: do_write(8'($urandom), 8'($urandom));
        1: do_read(8'($urandom), busy, drop, lat, extra);
        2: do_ops(8'($urandom), 8'($urandom), 8'($urandom), busy, drop, lat, extra);
        3: do_alu(8'($urandom), busy, drop, lat, extra);
        default: begin
          do b = 8'($urandom); while (b inside {8'hAA, 8'hBB, 8'hCC, 8'hDD});
          do_bad(b);
        end
      endcase
    end
    repeat (3) step();
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
